// File: rtl/pacman_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pacman_pkg                                                      |
// | Purpose  : Shared types and constants for the Pacman game-flow controller. |
// |            Holds the game state encoding, the life-count ceiling, counter  |
// |            widths and helpers that turn frame/dot counts into terminal     |
// |            counter values (a count of 0 behaves as 1).                     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pacman_pkg;

  typedef enum logic [2:0] {
    INTRO    = 3'd0,
    PLAY     = 3'd1,
    HIT      = 3'd2,
    RESPAWN  = 3'd3,
    GAMEOVER = 3'd4,
    WIN      = 3'd5
  } game_state_t;

  // Highest value the on-screen life counter can show.
  localparam logic [1:0] LC_MAX = 2'd3;

  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned DOT_CNT_W   = 10;

  // Terminal value of the frame counter for a wait of n frame ticks.
  // The counter starts at 0 on state entry, so the n-th tick arrives while it
  // holds n-1. A requested wait of 0 is stretched to a single tick.
  function automatic logic [FRAME_CNT_W-1:0] last_frame_idx(input int unsigned n);
    if (n == 0) begin
      return '0;
    end
    return FRAME_CNT_W'(n - 1);
  endfunction

  // Terminal value of the dot counter for a bonus every n food pulses.
  function automatic logic [DOT_CNT_W-1:0] last_dot_idx(input int unsigned n);
    if (n == 0) begin
      return '0;
    end
    return DOT_CNT_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_game_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pacman_game_ctrl_if                                             |
// | Purpose  : Bundles the game-flow controller's event inputs and its         |
// |            screen/motion control outputs.                                  |
// | Ports    : none; signals                                                   |
// |            start      - start/restart key, level                           |
// |            fail       - Pacman/ghost overlap from the colour mapper, level |
// |            food_eaten - one-Clk pulse per dot eaten                        |
// |            all_eaten  - level, no food left                                |
// |            LC[1:0]    - spare lives shown on screen                        |
// |            isIntro    - intro screen select                                |
// |            freeze     - motion blocks hold position                        |
// |            respawn    - motion blocks reload start positions               |
// |            game_over  - loss latched                                       |
// |            game_won   - win latched                                        |
// |          modports: master (drives the events), slave (the controller)      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pacman_game_ctrl_if;

  logic       start;
  logic       fail;
  logic       food_eaten;
  logic       all_eaten;
  logic [1:0] LC;
  logic       isIntro;
  logic       freeze;
  logic       respawn;
  logic       game_over;
  logic       game_won;

  modport master (
    output start, fail, food_eaten, all_eaten,
    input  LC, isIntro, freeze, respawn, game_over, game_won
  );

  modport slave (
    input  start, fail, food_eaten, all_eaten,
    output LC, isIntro, freeze, respawn, game_over, game_won
  );

endinterface
`default_nettype wire

// File: rtl/pacman_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pacman_edge_sync                                                |
// | Purpose  : Two-flop synchroniser followed by an edge register. Produces a  |
// |            one-clock pulse for every synchronised rising edge of an        |
// |            asynchronous level.                                             |
// | Ports    : clk     - destination clock                                     |
// |            rst_n   - asynchronous active-low reset                         |
// |            i_async - asynchronous input level                              |
// |            o_rise  - one-clk pulse per rising edge                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pacman_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = i_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Pulse is decoded from the two oldest stages, so a level that was high
  // while reset was applied still yields one pulse after release.
  assign o_rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/pacman_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pacman_game_ctrl                                                |
// | Purpose  : Frame-rate game-flow controller ahead of the colour mapper.     |
// |            Sequences intro, play, hit, respawn, game-over and win screens, |
// |            keeps the spare-life count and freezes/respawns the sprites.    |
// |            All waits are counted in vsync frames.                          |
// | Ports    : Clk       - system clock                                        |
// |            Reset_n   - asynchronous active-low reset                       |
// |            frame_clk - vsync-rate frame clock, asynchronous to Clk         |
// |            bus       - pacman_game_ctrl_if.slave (events in, controls out) |
// | Options  : PACMAN_EXTRA_LIFE_EN - award a life every EXTRA_LIFE_DOTS dots  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned LIVES_INIT      = 2,
  parameter int unsigned HIT_FRAMES      = 60,
  parameter int unsigned RESPAWN_FRAMES  = 30,
  parameter int unsigned EXTRA_LIFE_DOTS = 100
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  pacman_game_ctrl_if.slave bus
);

  localparam logic [1:0]             LC_INIT      = 2'(LIVES_INIT);
  localparam logic [FRAME_CNT_W-1:0] HIT_LAST     = last_frame_idx(HIT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] RESPAWN_LAST = last_frame_idx(RESPAWN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE    = FRAME_CNT_W'(1);
  localparam logic [DOT_CNT_W-1:0]   DOTS_LAST    = last_dot_idx(EXTRA_LIFE_DOTS);

  // --------------------------------------------------------------------------
  // Frame tick and start-key edge detection
  // --------------------------------------------------------------------------
  logic frame_tick;
  logic start_press;

  pacman_edge_sync u_frame_sync (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_async (frame_clk),
    .o_rise  (frame_tick)
  );

  pacman_edge_sync u_start_sync (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_async (bus.start),
    .o_rise  (start_press)
  );

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  game_state_t            state_q,     state_d;
  logic [1:0]             lc_q,        lc_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   fail_seen_q, fail_seen_d;
  logic                   is_intro_q,  is_intro_d;
  logic                   freeze_q,    freeze_d;
  logic                   respawn_q,   respawn_d;
  logic                   game_over_q, game_over_d;
  logic                   game_won_q,  game_won_d;

`ifdef PACMAN_EXTRA_LIFE_EN
  logic [DOT_CNT_W-1:0]   dot_cnt_q,   dot_cnt_d;
`else
  // Without bonus lives the dot pulse has no consumer.
  logic                   food_unused;
  assign food_unused = ^{bus.food_eaten, DOTS_LAST};
`endif

  always_comb begin
    state_d     = state_q;
    lc_d        = lc_q;
    frame_cnt_d = frame_cnt_q;
    fail_seen_d = fail_seen_q;
`ifdef PACMAN_EXTRA_LIFE_EN
    dot_cnt_d   = dot_cnt_q;
`endif

    case (state_q)
      INTRO: begin
        if (start_press) begin
          state_d = RESPAWN;
          lc_d    = LC_INIT;
        end
      end

      PLAY: begin
        // Collision outranks the last-dot win so the final hit still costs
        // a life. fail_seen makes a held overlap count only once.
        if (bus.fail && !fail_seen_q) begin
          state_d     = HIT;
          fail_seen_d = 1'b1;
        end else if (bus.all_eaten) begin
          state_d = WIN;
        end
      end

      HIT: begin
        if (frame_tick) begin
          if (frame_cnt_q == HIT_LAST) begin
            if (lc_q == 2'd0) begin
              state_d = GAMEOVER;
            end else begin
              lc_d    = lc_q - 2'd1;
              state_d = RESPAWN;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_ONE;
          end
        end
      end

      RESPAWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == RESPAWN_LAST) begin
            state_d = PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_ONE;
          end
        end
      end

      GAMEOVER, WIN: begin
        if (start_press) begin
          state_d = INTRO;
        end
      end

      default: begin
        state_d = INTRO;
      end
    endcase

    // Every state entry restarts the frame wait.
    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end

    // The collision latch is released only once play is (or becomes) active
    // with no overlap present; an overlap still held at the end of respawn
    // keeps it armed until the sprites separate.
    if ((state_d == PLAY) && !bus.fail) begin
      fail_seen_d = 1'b0;
    end

`ifdef PACMAN_EXTRA_LIFE_EN
    // Bonus life is granted from PLAY only. A coinciding HIT entry does not
    // interfere, because the matching decrement happens when HIT expires.
    if (state_q == INTRO) begin
      dot_cnt_d = '0;
    end else if ((state_q == PLAY) && bus.food_eaten) begin
      if (dot_cnt_q == DOTS_LAST) begin
        dot_cnt_d = '0;
        if (lc_q != LC_MAX) begin
          lc_d = lc_q + 2'd1;
        end
      end else begin
        dot_cnt_d = dot_cnt_q + DOT_CNT_W'(1);
      end
    end
`endif

    // Outputs follow the next state so they settle on the same edge as it.
    is_intro_d  = (state_d == INTRO);
    freeze_d    = (state_d != PLAY);
    respawn_d   = (state_d == RESPAWN);
    game_over_d = (state_d == GAMEOVER);
    game_won_d  = (state_d == WIN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= INTRO;
      lc_q        <= LC_INIT;
      frame_cnt_q <= '0;
      fail_seen_q <= 1'b0;
      is_intro_q  <= 1'b1;
      freeze_q    <= 1'b1;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      game_won_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lc_q        <= lc_d;
      frame_cnt_q <= frame_cnt_d;
      fail_seen_q <= fail_seen_d;
      is_intro_q  <= is_intro_d;
      freeze_q    <= freeze_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
      game_won_q  <= game_won_d;
    end
  end

`ifdef PACMAN_EXTRA_LIFE_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dot_cnt_q <= '0;
    end else begin
      dot_cnt_q <= dot_cnt_d;
    end
  end
`endif

  assign bus.LC        = lc_q;
  assign bus.isIntro   = is_intro_q;
  assign bus.freeze    = freeze_q;
  assign bus.respawn   = respawn_q;
  assign bus.game_over = game_over_q;
  assign bus.game_won  = game_won_q;

endmodule
`default_nettype wire

// File: tb/tb_pacman_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pacman_game_ctrl                                             |
// | Purpose  : Self-checking bench for pacman_game_ctrl: a table of directed   |
// |            frame-level steps, hand-written corner sequences, and a random  |
// |            phase compared cycle by cycle with a behavioural game model.    |
// | Ports    : none                                                            |
// | Options  : PACMAN_EXTRA_LIFE_EN - expects bonus lives when defined        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pacman_game_ctrl;

  logic Clk;
  logic Reset_n;
  logic frame_clk;

  pacman_game_ctrl_if bus ();

  pacman_game_ctrl #(
    .LIVES_INIT      (2),
    .HIT_FRAMES      (60),
    .RESPAWN_FRAMES  (30),
    .EXTRA_LIFE_DOTS (100)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] dut_o;
  assign dut_o = {1'b0, bus.LC, bus.isIntro, bus.freeze, bus.respawn,
                  bus.game_over, bus.game_won};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ev(input int lc, input bit intro, input bit frz,
                                    input bit rsp, input bit go, input bit won);
    return {1'b0, 2'(lc), intro, frz, rsp, go, won};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the edge, outputs read there too)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (4) cyc();
      frame_clk = 1'b0;
      repeat (4) cyc();
    end
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    repeat (4) cyc();
    bus.start = 1'b0;
    repeat (4) cyc();
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    int         frames;
    bit         st;
    bit         f;
    bit         ae;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input string n, input int fr, input bit st, input bit f,
                              input bit ae, input logic [7:0] e);
    vec_t v;
    v.name = n; v.frames = fr; v.st = st; v.f = f; v.ae = ae; v.exp = e;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural game model: phases with a frames-remaining countdown
  // ---------------------------------------------------------------------------
  localparam int PH_INTRO = 0, PH_PLAY = 1, PH_HIT = 2, PH_RESP = 3, PH_OVER = 4, PH_WIN = 5;

  int       m_phase, m_lc, m_left, m_dots;
  bit       m_hold;
  bit [3:1] fch, sth;   // input values seen at the last three edges

  task automatic model_reset();
    m_phase = PH_INTRO; m_lc = 2; m_left = 0; m_dots = 0; m_hold = 1'b0;
    fch = '0; sth = '0;
  endtask

  task automatic model_step(input bit f, input bit ae, input bit food, input bit fc, input bit st);
    bit tick, press;
    int prev;
    // The controller reacts to an input edge two clocks after sampling it.
    tick  = fch[2] & ~fch[3];
    press = sth[2] & ~sth[3];
    fch   = {fch[2:1], fc};
    sth   = {sth[2:1], st};
    prev  = m_phase;
    case (m_phase)
      PH_INTRO: if (press) begin m_phase = PH_RESP; m_left = 30; m_lc = 2; end
      PH_PLAY: begin
        if (f && !m_hold) begin m_phase = PH_HIT; m_left = 60; m_hold = 1'b1; end
        else if (ae) m_phase = PH_WIN;
      end
      PH_HIT: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_lc == 0) m_phase = PH_OVER;
          else begin m_lc--; m_phase = PH_RESP; m_left = 30; end
        end
      end
      PH_RESP: if (tick) begin
        m_left--;
        if (m_left == 0) m_phase = PH_PLAY;
      end
      default: if (press) m_phase = PH_INTRO;
    endcase
`ifdef PACMAN_EXTRA_LIFE_EN
    if (prev == PH_INTRO) m_dots = 0;
    else if (prev == PH_PLAY && food) begin
      m_dots++;
      if (m_dots == 100) begin
        m_dots = 0;
        if (m_lc < 3) m_lc++;
      end
    end
`else
    if (food && prev < 0) m_dots = 0;
`endif
    if (m_phase == PH_PLAY && !f) m_hold = 1'b0;
  endtask

  function automatic logic [7:0] model_out();
    return {1'b0, 2'(m_lc), m_phase == PH_INTRO, m_phase != PH_PLAY, m_phase == PH_RESP,
            m_phase == PH_OVER, m_phase == PH_WIN};
  endfunction

  int fc_left;

  initial begin
    logic [7:0] exp_a, exp_b;
    bit saw_rsp;

    Reset_n = 1'b0; frame_clk = 1'b0;
    bus.start = 1'b0; bus.fail = 1'b0; bus.food_eaten = 1'b0; bus.all_eaten = 1'b0;

    //               name                   frm st f ae  LC intro frz rsp go won
    tbl[0]  = mk("start_press",             0,  1, 0, 0, ev(2, 0, 1, 1, 0, 0));
    tbl[1]  = mk("respawn_29_ticks",        29, 0, 0, 0, ev(2, 0, 1, 1, 0, 0));
    tbl[2]  = mk("respawn_30_ticks",        1,  0, 0, 0, ev(2, 0, 0, 0, 0, 0));
    tbl[3]  = mk("first_hit",               0,  0, 1, 0, ev(2, 0, 1, 0, 0, 0));
    tbl[4]  = mk("hit_59_ticks",            59, 0, 1, 0, ev(2, 0, 1, 0, 0, 0));
    tbl[5]  = mk("hit_60_ticks",            1,  0, 1, 0, ev(1, 0, 1, 1, 0, 0));
    tbl[6]  = mk("respawn_fail_held",       30, 0, 1, 0, ev(1, 0, 0, 0, 0, 0));
    tbl[7]  = mk("play_fail_held",          100,0, 1, 0, ev(1, 0, 0, 0, 0, 0));
    tbl[8]  = mk("fail_released",           1,  0, 0, 0, ev(1, 0, 0, 0, 0, 0));
    tbl[9]  = mk("second_hit",              0,  0, 1, 0, ev(1, 0, 1, 0, 0, 0));
    tbl[10] = mk("second_hit_expiry",       60, 0, 0, 0, ev(0, 0, 1, 1, 0, 0));
    tbl[11] = mk("play_lc0",                30, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
    tbl[12] = mk("hit_lc0",                 0,  0, 1, 0, ev(0, 0, 1, 0, 0, 0));
    tbl[13] = mk("game_over_no_wrap",       60, 0, 0, 0, ev(0, 0, 1, 0, 1, 0));
    tbl[14] = mk("game_over_holds",         5,  0, 0, 0, ev(0, 0, 1, 0, 1, 0));
    tbl[15] = mk("game_over_to_intro",      0,  1, 0, 0, ev(0, 1, 1, 0, 0, 0));
    tbl[16] = mk("restart_reloads_lc",      0,  1, 0, 0, ev(2, 0, 1, 1, 0, 0));
    tbl[17] = mk("restart_play",            30, 0, 0, 0, ev(2, 0, 0, 0, 0, 0));
    tbl[18] = mk("fail_beats_all_eaten",    0,  0, 1, 1, ev(2, 0, 1, 0, 0, 0));
    tbl[19] = mk("hit_expiry_all_eaten",    60, 0, 0, 1, ev(1, 0, 1, 1, 0, 0));
    tbl[20] = mk("win_after_respawn",       30, 0, 0, 1, ev(1, 0, 1, 0, 0, 1));
    tbl[21] = mk("win_to_intro",            0,  1, 0, 0, ev(1, 1, 1, 0, 0, 0));

    repeat (3) cyc();
    check("reset_values", dut_o, ev(2, 1, 1, 0, 0, 0));
    Reset_n = 1'b1;
    repeat (2) cyc();
    check("idle_intro", dut_o, ev(2, 1, 1, 0, 0, 0));

    for (int i = 0; i < 22; i++) begin
      bus.fail      = tbl[i].f;
      bus.all_eaten = tbl[i].ae;
      if (tbl[i].st) press_start();
      run_frames(tbl[i].frames);
      repeat (2) cyc();
      check(tbl[i].name, dut_o, tbl[i].exp);
    end

    // all_eaten alone: win registered on the very next edge.
    press_start();
    run_frames(30);
    check("play_before_win", dut_o, ev(2, 0, 0, 0, 0, 0));
    bus.all_eaten = 1'b1;
    cyc();
    check("all_eaten_next_clk", dut_o, ev(2, 0, 1, 0, 0, 1));
    bus.all_eaten = 1'b0;
    press_start();

    // Reach PLAY with one spare life, then exercise dots and async reset.
    press_start();
    run_frames(30);
    bus.fail = 1'b1;
    repeat (2) cyc();
    bus.fail = 1'b0;
    run_frames(90);
    check("play_lc1", dut_o, ev(1, 0, 0, 0, 0, 0));

`ifdef PACMAN_EXTRA_LIFE_EN
    exp_a = ev(2, 0, 0, 0, 0, 0);
    exp_b = ev(3, 0, 0, 0, 0, 0);
`else
    exp_a = ev(1, 0, 0, 0, 0, 0);
    exp_b = ev(1, 0, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 100; i++) begin
      bus.food_eaten = 1'b1; cyc();
      bus.food_eaten = 1'b0; cyc();
    end
    check("dots_100", dut_o, exp_a);
    for (int i = 0; i < 200; i++) begin
      bus.food_eaten = 1'b1; cyc();
      bus.food_eaten = 1'b0; cyc();
    end
    check("dots_300_saturate", dut_o, exp_b);

    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_reset_mid_play", dut_o, ev(2, 1, 1, 0, 0, 0));
    saw_rsp = 1'b0;
    repeat (3) begin cyc(); saw_rsp |= bus.respawn; end
    Reset_n = 1'b1;
    repeat (5) begin cyc(); saw_rsp |= bus.respawn; end
    check("no_respawn_after_reset", {saw_rsp, dut_o[6:0]}, ev(2, 1, 1, 0, 0, 0));

    // Random phase against the behavioural model.
    bus.start = 1'b0; bus.fail = 1'b0; bus.food_eaten = 1'b0; bus.all_eaten = 1'b0;
    frame_clk = 1'b0;
    Reset_n = 1'b0;
    model_reset();
    cyc();
    Reset_n = 1'b1;
    fc_left = 3;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 3999) == 0) begin
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("rnd_async_reset", dut_o, model_out());
        cyc();
        Reset_n = 1'b1;
        continue;
      end
      if ($urandom_range(0, 39) == 0)  bus.fail      = ~bus.fail;
      if ($urandom_range(0, 149) == 0) bus.all_eaten = ~bus.all_eaten;
      if ($urandom_range(0, 59) == 0)  bus.start     = ~bus.start;
      bus.food_eaten = ($urandom_range(0, 2) == 0);
      if (fc_left == 0) begin
        frame_clk = ~frame_clk;
        fc_left   = $urandom_range(1, 5);
      end else begin
        fc_left--;
      end
      model_step(bus.fail, bus.all_eaten, bus.food_eaten, frame_clk, bus.start);
      cyc();
      check("rnd_cycle", dut_o, model_out());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
